// File: rtl/ascon_hash_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ascon_hash_host                                            |
// | Description : Hardware initiator for the ASCON engine's 16-bit toggle-   |
// |               handshake board interface. Streams pre-padded 64-bit       |
// |               blocks as CONF/MSG words, then issues OK acknowledges to   |
// |               read back the 256-bit ASCON-HASH digest.                   |
// | Options     : define HOST_TIMEOUT_EN to enable the handshake watchdog    |
// |               (TIMEOUT_CYCLES) and the sticky err flag.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ascon_hash_host #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [63:0]  s_block,
   input  logic         s_valid,
   input  logic         s_last,
   output logic         s_ready,
   output logic [15:0]  bd_in_data,
   output logic [15:0]  bd_in_config,
   input  logic [15:0]  bd_out_data,
   input  logic [15:0]  bd_out_config,
   output logic [255:0] hash,
   output logic         hash_valid,
   output logic         busy,
   output logic         err
);

   // Word type codes, matching the engine's ascon_constants.vh
   localparam logic [3:0] c_type_conf = 4'h1;
   localparam logic [3:0] c_type_msg  = 4'h2;
   localparam logic [3:0] c_type_ok   = 4'h3;

   typedef enum logic [2:0] {
      c_st_idle      = 3'd0,
      c_st_wait_conf = 3'd1,
      c_st_load      = 3'd2,
      c_st_send      = 3'd3,
      c_st_wait_w    = 3'd4,
      c_st_fin       = 3'd5,
      c_st_wait_h    = 3'd6,
      c_st_release   = 3'd7
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [63:0]    r_block;
   logic [63:0]    w_block_nxt;
   logic           r_last;
   logic           w_last_nxt;
   logic [1:0]     r_word_idx;
   logic [1:0]     w_word_idx_nxt;
   logic [3:0]     r_rd_idx;
   logic [3:0]     w_rd_idx_nxt;
   logic [15:0]    r_data;
   logic [15:0]    r_cfg;
   logic           r_rx_exp;
   logic           w_rx_exp_nxt;
   logic           r_rx_tgl;
   logic [255:0]   r_hash;
   logic [255:0]   w_hash_nxt;
   logic           r_hash_valid;
   logic           w_hash_valid_nxt;

   // Word issue request from the FSM
   logic           w_issue;
   logic [3:0]     w_issue_type;
   logic           w_issue_frame;
   logic           w_issue_final;
   logic           w_issue_hsel;
   logic [15:0]    w_issue_data;

   logic           w_ack;
   logic           w_timeout;
   logic           w_err_set;
   logic           w_err_clr;
   logic [5:0]     w_blk_msb;
   logic [7:0]     w_hash_msb;
   logic [15:0]    w_blk_word;
   logic           w_unused_bits;

   // The rx toggle is registered once; comparing it to rx_exp gives a
   // clean single-cycle ack because rx_exp flips on the cycle it is consumed.
   assign w_ack = (r_rx_tgl != r_rx_exp);

   // 63-16k and 255-16r expressed as bit-inverted indices
   assign w_blk_msb  = {~r_word_idx, 4'hF};
   assign w_hash_msb = {~r_rd_idx, 4'hF};
   assign w_blk_word = r_block[w_blk_msb -: 16];

   assign s_ready      = (r_state == c_st_load);
   assign busy         = (r_state != c_st_idle);
   assign bd_in_data   = r_data;
   assign bd_in_config = r_cfg;
   assign hash         = r_hash;
   assign hash_valid   = r_hash_valid;

   // Next-state and word-issue decode
   always_comb begin
      w_state_nxt      = r_state;
      w_block_nxt      = r_block;
      w_last_nxt       = r_last;
      w_word_idx_nxt   = r_word_idx;
      w_rd_idx_nxt     = r_rd_idx;
      w_rx_exp_nxt     = r_rx_exp;
      w_hash_nxt       = r_hash;
      w_hash_valid_nxt = 1'b0;
      w_issue          = 1'b0;
      w_issue_type     = c_type_ok;
      w_issue_frame    = 1'b0;
      w_issue_final    = 1'b0;
      w_issue_hsel     = 1'b0;
      w_issue_data     = 16'h0000;
      w_err_set        = 1'b0;
      w_err_clr        = 1'b0;

      case (r_state)
         c_st_idle: begin
            if (start) begin
               w_issue       = 1'b1;
               w_issue_type  = c_type_conf;
               w_issue_frame = 1'b1;
               w_issue_hsel  = 1'b1;
               w_err_clr     = 1'b1;
               w_state_nxt   = c_st_wait_conf;
            end
         end

         c_st_wait_conf: begin
            if (w_ack) begin
               w_rx_exp_nxt = ~r_rx_exp;
               w_state_nxt  = c_st_load;
            end else if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = c_st_idle;
            end
         end

         c_st_load: begin
            if (s_valid) begin
               w_block_nxt    = s_block;
               w_last_nxt     = s_last;
               w_word_idx_nxt = 2'd0;
               w_state_nxt    = c_st_send;
            end
         end

         c_st_send: begin
            w_issue       = 1'b1;
            w_issue_type  = c_type_msg;
            w_issue_data  = w_blk_word;
            w_issue_frame = r_last && (r_word_idx == 2'd3);
            w_issue_final = r_last && (r_word_idx == 2'd3);
            w_state_nxt   = c_st_wait_w;
         end

         c_st_wait_w: begin
            if (w_ack) begin
               w_rx_exp_nxt = ~r_rx_exp;
               if (r_word_idx != 2'd3) begin
                  w_word_idx_nxt = r_word_idx + 2'd1;
                  w_state_nxt    = c_st_send;
               end else if (r_last) begin
                  w_state_nxt = c_st_fin;
               end else begin
                  w_state_nxt = c_st_load;
               end
            end else if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = c_st_idle;
            end
         end

         c_st_fin: begin
            w_issue       = 1'b1;
            w_issue_type  = c_type_ok;
            w_issue_frame = 1'b1;
            w_issue_final = 1'b1;
            w_rd_idx_nxt  = 4'd0;
            w_state_nxt   = c_st_wait_h;
         end

         c_st_wait_h: begin
            if (w_ack) begin
               w_rx_exp_nxt                 = ~r_rx_exp;
               w_hash_nxt[w_hash_msb -: 16] = bd_out_data;
               if (r_rd_idx != 4'd15) begin
                  w_issue      = 1'b1;
                  w_issue_type = c_type_ok;
                  w_rd_idx_nxt = r_rd_idx + 4'd1;
               end else begin
                  w_state_nxt = c_st_release;
               end
            end else if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = c_st_idle;
            end
         end

         c_st_release: begin
            // Final release word: the engine does not answer it
            w_issue          = 1'b1;
            w_issue_type     = c_type_ok;
            w_issue_frame    = 1'b1;
            w_issue_final    = 1'b1;
            w_hash_valid_nxt = 1'b1;
            w_state_nxt      = c_st_idle;
         end

         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   // FSM, datapath and registered word outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= c_st_idle;
         r_block      <= 64'h0;
         r_last       <= 1'b0;
         r_word_idx   <= 2'd0;
         r_rd_idx     <= 4'd0;
         r_data       <= 16'h0000;
         r_cfg        <= 16'h0000;
         r_rx_exp     <= 1'b0;
         r_rx_tgl     <= 1'b0;
         r_hash       <= 256'h0;
         r_hash_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_block      <= w_block_nxt;
         r_last       <= w_last_nxt;
         r_word_idx   <= w_word_idx_nxt;
         r_rd_idx     <= w_rd_idx_nxt;
         r_rx_exp     <= w_rx_exp_nxt;
         r_rx_tgl     <= bd_out_config[2];
         r_hash       <= w_hash_nxt;
         r_hash_valid <= w_hash_valid_nxt;
         if (w_issue) begin
            r_data <= w_issue_data;
            r_cfg  <= {5'b00000, w_issue_type, w_issue_frame, w_issue_final,
                       3'b000, w_issue_hsel, ~r_cfg[0]};
         end
      end
   end

`ifdef HOST_TIMEOUT_EN
   localparam int c_tmo_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [c_tmo_w-1:0] r_tmo_cnt;
   logic               r_err;
   logic               w_in_wait;

   assign w_in_wait = (r_state == c_st_wait_conf) || (r_state == c_st_wait_w) ||
                      (r_state == c_st_wait_h);
   assign w_timeout = w_in_wait && !w_ack &&
                      (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1));
   assign err       = r_err;

   // Watchdog: counts idle cycles in a WAIT state, cleared by every ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmo_cnt <= '0;
      end else if (!w_in_wait || w_ack || w_timeout) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
      end
   end

   // Sticky error flag, cleared when the next job starts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_err_clr) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   // Response bits the host does not interpret
   assign w_unused_bits = ^{bd_out_config[15:3], bd_out_config[1:0], w_err_set,
                            w_err_clr, (TIMEOUT_CYCLES != 0)};

endmodule
`default_nettype wire

// File: tb/tb_ascon_hash_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ascon_hash_host                                         |
// | Description : Scoreboard bench for ascon_hash_host with a toggle-        |
// |               handshake responder standing in for the engine.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ascon_hash_host;

   localparam logic [3:0] c_type_conf = 4'h1;
   localparam logic [3:0] c_type_msg  = 4'h2;
   localparam logic [3:0] c_type_ok   = 4'h3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [63:0]  s_block = 64'h0;
   logic         s_valid = 1'b0;
   logic         s_last = 1'b0;
   logic         s_ready;
   logic [15:0]  bd_in_data;
   logic [15:0]  bd_in_config;
   logic [15:0]  bd_out_data;
   logic [15:0]  bd_out_config;
   logic [255:0] hash;
   logic         hash_valid;
   logic         busy;
   logic         err;

   ascon_hash_host #(.TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .s_block       (s_block),
      .s_valid       (s_valid),
      .s_last        (s_last),
      .s_ready       (s_ready),
      .bd_in_data    (bd_in_data),
      .bd_in_config  (bd_in_config),
      .bd_out_data   (bd_out_data),
      .bd_out_config (bd_out_config),
      .hash          (hash),
      .hash_valid    (hash_valid),
      .busy          (busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   logic [30:0]  word_q[$];
   logic [255:0] hash_q[$];
   logic [63:0]  blk_mem[8];

   // Responder state
   logic        seen_tgl;
   logic [30:0] prev_word;
   logic [15:0] rsp_d;
   logic [7:0]  rsp_tag = 8'h00;
   bit          rsp_hold;
   bit          withhold = 1'b0;
   int          rsp_dly;
   int          reads;
   int          msg_idx;
   int          word_cnt = 0;
   int          unstable = 0;
   int          done_cnt = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [30:0] mk(input logic [3:0] typ, input logic frame,
                                      input logic fin, input logic hsel, input logic [15:0] data);
      return {5'b00000, typ, frame, fin, 3'b000, hsel, data};
   endfunction

   // Digest the responder returns for a job: word r is {tag, 0xC, r}
   function automatic logic [255:0] exp_hash(input logic [7:0] tag);
      logic [255:0] h;
      h = 256'h0;
      for (int r = 0; r < 16; r++) h = {h[239:0], tag, 4'hC, 4'(r)};
      return h;
   endfunction

   // Engine stand-in: checks every issued word against the scoreboard and acks it
   initial begin
      bd_out_data   = 16'h0000;
      bd_out_config = 16'h0000;
      seen_tgl      = 1'b0;
      prev_word     = 31'h0;
      reads         = 0;
      msg_idx       = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            bd_out_data   = 16'h0000;
            bd_out_config = 16'h0000;
            seen_tgl      = 1'b0;
            prev_word     = 31'h0;
            reads         = 0;
            msg_idx       = 0;
         end else if (bd_in_config[0] == seen_tgl) begin
            if ({bd_in_config[15:1], bd_in_data} != prev_word) unstable++;
         end else begin
            seen_tgl  = bd_in_config[0];
            prev_word = {bd_in_config[15:1], bd_in_data};
            word_cnt++;
            if (word_q.size() == 0) begin
               checks++;
               $display("FAIL extra_word: got %h expected no word", prev_word);
            end else begin
               check("word", 256'(prev_word), 256'(word_q.pop_front()));
            end
            if (bd_in_config[10:7] == c_type_ok && reads == 16) begin
               reads = 0;
            end else begin
               rsp_d    = 16'h0000;
               rsp_hold = 1'b0;
               if (bd_in_config[10:7] == c_type_ok) begin
                  rsp_d = {rsp_tag, 4'hC, 4'(reads)};
                  reads++;
               end
               if (bd_in_config[10:7] == c_type_conf) msg_idx = 0;
               if (bd_in_config[10:7] == c_type_msg) begin
                  rsp_hold = withhold && (msg_idx == 1);
                  msg_idx++;
               end
               if (!rsp_hold) begin
                  rsp_dly = word_cnt % 3;
                  for (int i = 0; i < rsp_dly; i++) begin
                     @(negedge clk);
                     if (!rst) break;
                  end
                  if (rst) begin
                     bd_out_data      = rsp_d;
                     bd_out_config[2] = ~bd_out_config[2];
                  end
               end
            end
         end
      end
   end

   // Digest monitor
   initial begin
      forever begin
         @(negedge clk);
         if (hash_valid) begin
            if (hash_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_hash_valid: got %h expected no pulse", hash);
            end else begin
               check("hash", hash, hash_q.pop_front());
            end
            done_cnt++;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic send_block(input logic [63:0] blk, input bit last);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      s_block = blk;
      s_last  = last;
      s_valid = 1'b1;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (s_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!ok) begin
         checks++;
         $display("FAIL block_accept: got s_ready=0 expected s_ready=1");
      end
   endtask

   task automatic check_reset_vals();
      check("rst_data", 256'(bd_in_data), 256'(16'h0000));
      check("rst_cfg", 256'(bd_in_config), 256'(16'h0000));
      check("rst_s_ready", 256'(s_ready), 256'(1'b0));
      check("rst_hash", hash, 256'h0);
      check("rst_hash_valid", 256'(hash_valid), 256'(1'b0));
      check("rst_busy", 256'(busy), 256'(1'b0));
      check("rst_err", 256'(err), 256'(1'b0));
   endtask

   // One hash job over blk_mem[0..nblk-1]; abort_read > 0 resets mid-readback
   task automatic run_job(input logic [7:0] tag, input int nblk, input int gap_after,
                          input int gap_len, input int abort_read);
      int base_done;
      int base_words;
      logic [255:0] exp_h;
      rsp_tag = tag;
      word_q.push_back(mk(c_type_conf, 1'b1, 1'b0, 1'b1, 16'h0000));
      for (int b = 0; b < nblk; b++)
         for (int k = 0; k < 4; k++)
            word_q.push_back(mk(c_type_msg, (b == nblk-1) && (k == 3), (b == nblk-1) && (k == 3),
                                1'b0, 16'(blk_mem[b] >> (48 - 16*k))));
      word_q.push_back(mk(c_type_ok, 1'b1, 1'b1, 1'b0, 16'h0000));
      for (int r = 0; r < 15; r++) word_q.push_back(mk(c_type_ok, 1'b0, 1'b0, 1'b0, 16'h0000));
      word_q.push_back(mk(c_type_ok, 1'b1, 1'b1, 1'b0, 16'h0000));
      exp_h = exp_hash(tag);
      hash_q.push_back(exp_h);
      base_done  = done_cnt;
      base_words = word_cnt;

      pulse_start();
      for (int b = 0; b < nblk; b++) begin
         if (b == gap_after) begin
            repeat (gap_len) @(posedge clk);
            pulse_start();
         end
         send_block(blk_mem[b], b == nblk-1);
      end

      if (abort_read > 0) begin
         for (int i = 0; i < 3000 && reads < abort_read + 1; i++) @(negedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         check_reset_vals();
         word_q.delete();
         hash_q.delete();
         repeat (2) @(posedge clk);
         #1 rst = 1'b1;
         return;
      end

      for (int i = 0; i < 3000 && done_cnt == base_done; i++) @(negedge clk);
      if (done_cnt == base_done) begin
         checks++;
         $display("FAIL job_timeout: got no hash_valid expected pulse (tag %h)", tag);
         word_q.delete();
         hash_q.delete();
      end
      repeat (3) @(negedge clk);
      check("word_count", 256'(word_cnt - base_words), 256'(1 + 4*nblk + 17));
      check("hash_hold", hash, exp_h);
      check("busy_idle", 256'(busy), 256'(1'b0));
      check("s_ready_idle", 256'(s_ready), 256'(1'b0));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);

      // Empty message
      blk_mem[0] = 64'h8000000000000000;
      run_job(8'hA5, 1, -1, 0, 0);

      // "The quick brown fox jumps over the lazy dog", padded
      blk_mem[0] = 64'h5468652071756963;
      blk_mem[1] = 64'h6b2062726f776e20;
      blk_mem[2] = 64'h666f78206a756d70;
      blk_mem[3] = 64'h73206f7665722074;
      blk_mem[4] = 64'h6865206c617a7920;
      blk_mem[5] = 64'h646f678000000000;
      run_job(8'h3C, 6, -1, 0, 0);

      // Same sentence with a 7-cycle s_valid gap between blocks 2 and 3
      run_job(8'h77, 6, 2, 7, 0);

      // Reset while reading back word r=7, then a fresh empty job
      blk_mem[0] = 64'h8000000000000000;
      run_job(8'h11, 1, -1, 0, 7);
      repeat (2) @(posedge clk);
      run_job(8'h5E, 1, -1, 0, 0);

`ifdef HOST_TIMEOUT_EN
      // Responder withholds the ack of the second MSG word
      withhold = 1'b1;
      rsp_tag  = 8'h99;
      word_q.push_back(mk(c_type_conf, 1'b1, 1'b0, 1'b1, 16'h0000));
      word_q.push_back(mk(c_type_msg, 1'b0, 1'b0, 1'b0, 16'h8000));
      word_q.push_back(mk(c_type_msg, 1'b0, 1'b0, 1'b0, 16'h0000));
      pulse_start();
      send_block(64'h8000000000000000, 1'b1);
      for (int i = 0; i < 200 && !err; i++) @(negedge clk);
      check("tmo_err", 256'(err), 256'(1'b1));
      check("tmo_busy", 256'(busy), 256'(1'b0));
      check("tmo_words_left", 256'(word_q.size()), 256'(0));
      word_q.delete();
      withhold = 1'b0;
      repeat (5) @(negedge clk);
      run_job(8'h42, 1, -1, 0, 0);
      check("tmo_err_cleared", 256'(err), 256'(1'b0));
`endif

      check("word_stability", 256'(unstable), 256'(0));
      check("err_final", 256'(err), 256'(1'b0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
